hdmi_line_fetch: RTL and testbench

HDMI_LINE_FETCH -- requirements
Module: hdmi_line_fetch

---
 rtl/hdmi_line_fetch.sv | 149 ++++++++++++++
 tb/tb_hdmi_line_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_line_fetch.sv
// Double-buffered line fetcher for the HDMI scan-out path.
// Pulls one video line of 64-bit words from memory into one of two line banks,
// while the other bank feeds the 8-pixel output stage.
module hdmi_line_fetch #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter logic [18:0] BASE_ADDR = 19'd0,
  parameter int          HBW       = $clog2(H_ACTIVE),
  parameter int          VBW       = $clog2(V_ACTIVE)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           vs_in,
  input  logic           de_in,
  input  logic [HBW-1:0] x,
  input  logic [VBW-1:0] y,
  output logic           mem_req,
  output logic [18:0]    mem_addr,
  input  logic           mem_gnt,
  input  logic           mem_rvalid,
  input  logic [63:0]    mem_rdata,
  output logic [63:0]    data_out,
  output logic           underrun
);

  localparam int WPL = H_ACTIVE / 8;
  localparam int WAW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [WAW-1:0] LAST_WORD = WAW'(WPL - 1);
  localparam logic [VBW-1:0] LAST_LINE = VBW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t         state, state_next;
  logic [VBW-1:0] line_q, line_next;
  logic [WAW-1:0] word_q, word_next;
  logic           pend_q, pend_next;
  logic [VBW-1:0] pend_line_q, pend_line_next;
  logic           vs_prev, de_prev;
  logic           frame_trig, line_trig, trig;
  logic [VBW-1:0] trig_line;
  logic           bank_we;
  logic [WAW-1:0] rd_word;

  logic [63:0] bank0 [WPL];
  logic [63:0] bank1 [WPL];

  // Edge detection on the timing signals; a frame start outranks a line start seen in the same cycle.
  always_comb begin
    frame_trig = vs_in & ~vs_prev;
    line_trig  = de_in & ~de_prev & (y < LAST_LINE);
    trig       = frame_trig | line_trig;
    trig_line  = frame_trig ? '0 : y + VBW'(1);
    rd_word    = WAW'(x >> 3);
  end

  // Fetch sequencing: one read in flight at a time, new triggers abort the current line once its read returns.
  always_comb begin
    state_next     = state;
    line_next      = line_q;
    word_next      = word_q;
    pend_next      = pend_q;
    pend_line_next = pend_line_q;
    bank_we        = 1'b0;
    mem_req        = 1'b0;
    mem_addr       = 19'd0;
    case (state)
      IDLE: begin
        if (trig) begin
          state_next = REQ;
          line_next  = trig_line;
          word_next  = '0;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = BASE_ADDR + 19'(line_q) * 19'(WPL) + 19'(word_q);
        if (trig) begin
          pend_next      = 1'b1;
          pend_line_next = trig_line;
        end
        if (mem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (trig) begin
          pend_next      = 1'b1;
          pend_line_next = trig_line;
        end
        if (mem_rvalid) begin
          bank_we = 1'b1;
          if (trig || pend_q) begin
            state_next = REQ;
            line_next  = trig ? trig_line : pend_line_q;
            word_next  = '0;
            pend_next  = 1'b0;
          end else if (word_q == LAST_WORD) begin
            state_next = IDLE;
          end else begin
            state_next = REQ;
            word_next  = word_q + WAW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers and the sticky underrun flag (a line start that finds the fetcher busy with nothing queued).
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      line_q      <= '0;
      word_q      <= '0;
      pend_q      <= 1'b0;
      pend_line_q <= '0;
      vs_prev     <= 1'b0;
      de_prev     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_next;
      line_q      <= line_next;
      word_q      <= word_next;
      pend_q      <= pend_next;
      pend_line_q <= pend_line_next;
      vs_prev     <= vs_in;
      de_prev     <= de_in;
      if (line_trig && (state != IDLE) && !pend_q) underrun <= 1'b1;
    end
  end

  // Returned words land in the bank selected by the line's parity; banks keep their contents across reset.
  always_ff @(posedge clock) begin
    if (bank_we && !reset) begin
      if (line_q[0]) bank1[word_q] <= mem_rdata;
      else           bank0[word_q] <= mem_rdata;
    end
  end

  // Pixel read port: one registered 8-pixel word per cycle, blanked outside the active area.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= 64'd0;
    end else if (de_in) begin
      data_out <= y[0] ? bank1[rd_word] : bank0[rd_word];
    end else begin
      data_out <= 64'd0;
    end
  end

endmodule

// File: tb/tb_hdmi_line_fetch.sv
// Scoreboard bench for hdmi_line_fetch with a small memory model.
module tb_hdmi_line_fetch;

  localparam int WPL = 80;

  logic        clock = 1'b0;
  logic        reset, vs_in, de_in;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        mem_req, mem_gnt, mem_rvalid, underrun;
  logic [18:0] mem_addr;
  logic [63:0] mem_rdata, data_out;

  int check_count = 0;
  int pass_count  = 0;

  logic [18:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];

  logic        gnt_en    = 1'b1;
  int          gnt_delay = 0;
  int          req_age   = 0;
  logic [1:0]  rv_pipe   = 2'b00;
  logic [18:0] rv_addr0, rv_addr1;
  logic        rd_issue  = 1'b0;
  logic        rd_fire   = 1'b0;
  logic        held      = 1'b0;
  logic [18:0] held_addr;

  always #5 clock = ~clock;

  hdmi_line_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .vs_in      (vs_in),
    .de_in      (de_in),
    .x          (x),
    .y          (y),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .data_out   (data_out),
    .underrun   (underrun)
  );

  function automatic logic [63:0] mem_word(input logic [18:0] a);
    return {8{a[7:0]}};
  endfunction

  assign mem_gnt    = gnt_en & mem_req & (req_age >= gnt_delay);
  assign mem_rvalid = rv_pipe[1];
  assign mem_rdata  = mem_word(rv_addr1);

  // Memory model: optional grant delay, read data returned two cycles after each grant.
  always @(posedge clock) begin
    if (!mem_req || mem_gnt) req_age <= 0;
    else                     req_age <= req_age + 1;
    rv_pipe  <= {rv_pipe[0], mem_req & mem_gnt};
    rv_addr0 <= mem_addr;
    rv_addr1 <= rv_addr0;
    rd_fire  <= rd_issue;
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitor: request hold stability, granted addresses and pixel words against the scoreboard queues.
  always @(negedge clock) begin
    if (held && !reset)
      checkOutput("req_hold", {44'd0, mem_req, mem_addr}, {44'd0, 1'b1, held_addr});
    held      <= mem_req && !mem_gnt && !reset;
    held_addr <= mem_addr;
    if (mem_req && mem_gnt) begin
      if (exp_addr_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected_req: got addr %0d expected no request", mem_addr);
      end else begin
        checkOutput("mem_addr", {45'd0, mem_addr}, {45'd0, exp_addr_q.pop_front()});
      end
    end
    if (rd_fire) begin
      if (exp_data_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL data_scoreboard: got %h expected no entry", data_out);
      end else begin
        checkOutput("data_out", data_out, exp_data_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      rd_issue = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic de, input logic [8:0] yy, input logic [9:0] xx,
                               input logic chk, input logic [63:0] exp);
    @(negedge clock);
    de_in    = de;
    y        = yy;
    x        = xx;
    rd_issue = chk;
    if (chk) exp_data_q.push_back(exp);
  endtask

  task automatic push_line(input int line, input int first, input int last);
    for (int w = first; w <= last; w++) exp_addr_q.push_back(19'(line * WPL + w));
  endtask

  task automatic wait_fetch_done(input string name, input int budget);
    int n = 0;
    while (exp_addr_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (exp_addr_q.size() != 0) begin
      check_count++;
      $display("[TB] FAIL %s_timeout: got %0d words outstanding expected 0", name, exp_addr_q.size());
      exp_addr_q.delete();
    end
    tick(4);
    checkOutput(name, {63'd0, mem_req}, 64'd0);
  endtask

  initial begin
    logic any_req;
    logic found;
    reset = 1'b1; vs_in = 1'b0; de_in = 1'b0; x = '0; y = '0;
    tick(3);
    checkOutput("reset_mem_req",  {63'd0, mem_req}, 64'd0);
    checkOutput("reset_mem_addr", {45'd0, mem_addr}, 64'd0);
    checkOutput("reset_data_out", data_out, 64'd0);
    checkOutput("reset_underrun", {63'd0, underrun}, 64'd0);
    reset = 1'b0;
    tick(2);

    // Frame start fetches line 0, addresses 0..79 in order
    push_line(0, 0, 79);
    vs_in = 1'b1;
    wait_fetch_done("idle_after_frame", 600);
    vs_in = 1'b0;

    // Reads of line 0 while line 1 is fetched by the de_in rise at y=0
    push_line(1, 0, 79);
    applyStimulus(1'b1, 9'd0, 10'd3,         1'b1, {8{8'd0}});
    applyStimulus(1'b1, 9'd0, 10'd11,        1'b1, {8{8'd1}});
    applyStimulus(1'b1, 9'd0, 10'(8*42 + 3), 1'b1, {8{8'd42}});
    applyStimulus(1'b1, 9'd0, 10'd635,       1'b1, {8{8'd79}});
    wait_fetch_done("idle_after_line1", 600);
    applyStimulus(1'b1, 9'd1, 10'(8*5 + 7),  1'b1, {8{8'd85}});
    applyStimulus(1'b0, 9'd1, 10'd0,         1'b1, 64'd0);
    tick(2);

    // Line trigger at y=5 fills bank 0 with line 6 (addresses 480..559)
    push_line(6, 0, 79);
    applyStimulus(1'b1, 9'd5, 10'd0,   1'b1, {8{8'd80}});
    wait_fetch_done("idle_after_line6", 600);
    applyStimulus(1'b1, 9'd6, 10'd0,   1'b1, {8{8'd224}});
    applyStimulus(1'b1, 9'd6, 10'd635, 1'b1, {8{8'd47}});
    applyStimulus(1'b0, 9'd6, 10'd0,   1'b0, 64'd0);
    tick(2);

    // The last line never requests a fetch
    applyStimulus(1'b1, 9'd479, 10'd0, 1'b0, 64'd0);
    any_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      any_req = any_req | mem_req;
    end
    checkOutput("no_fetch_last_line", {63'd0, any_req}, 64'd0);
    applyStimulus(1'b0, 9'd0, 10'd0, 1'b0, 64'd0);
    tick(2);

    // Grant delayed by 3 cycles per word, line 11 into bank 1
    gnt_delay = 3;
    push_line(11, 0, 79);
    applyStimulus(1'b1, 9'd10, 10'd0, 1'b0, 64'd0);
    wait_fetch_done("idle_after_line11", 1500);
    applyStimulus(1'b0, 9'd10, 10'd0, 1'b0, 64'd0);
    gnt_delay = 0;
    tick(2);

    // Two line triggers with grant withheld raise a sticky underrun
    gnt_en = 1'b0;
    applyStimulus(1'b1, 9'd20, 10'd0, 1'b0, 64'd0);
    tick(3);
    checkOutput("stall_req",      {63'd0, mem_req},  64'd1);
    checkOutput("underrun_first", {63'd0, underrun}, 64'd0);
    applyStimulus(1'b0, 9'd20, 10'd0, 1'b0, 64'd0);
    tick(2);
    applyStimulus(1'b1, 9'd21, 10'd0, 1'b0, 64'd0);
    tick(2);
    checkOutput("underrun_set",  {63'd0, underrun}, 64'd1);
    applyStimulus(1'b0, 9'd21, 10'd0, 1'b0, 64'd0);
    tick(10);
    checkOutput("underrun_held", {63'd0, underrun}, 64'd1);
    reset = 1'b1;
    tick(2);
    checkOutput("rst2_underrun", {63'd0, underrun}, 64'd0);
    checkOutput("rst2_mem_req",  {63'd0, mem_req},  64'd0);
    checkOutput("rst2_mem_addr", {45'd0, mem_addr}, 64'd0);
    reset  = 1'b0;
    gnt_en = 1'b1;
    tick(2);

    // Frame start during WAIT on line 7 word 10: word 10 completes, then line 0 restarts
    push_line(7, 0, 10);
    push_line(0, 0, 79);
    applyStimulus(1'b1, 9'd6, 10'd0, 1'b0, 64'd0);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick(1);
      if (mem_req && mem_gnt && mem_addr == 19'd570) found = 1'b1;
    end
    if (!found) begin
      check_count++;
      $display("[TB] FAIL wait_word10_timeout: got no grant for addr 570 expected one");
    end
    tick(1);
    vs_in = 1'b1;
    wait_fetch_done("idle_after_abort", 800);
    vs_in = 1'b0;
    applyStimulus(1'b0, 9'd6, 10'd0, 1'b0, 64'd0);
    tick(2);
    push_line(8, 0, 79);
    applyStimulus(1'b1, 9'd7, 10'd80, 1'b1, {8{8'd58}});
    applyStimulus(1'b1, 9'd7, 10'd88, 1'b1, {8{8'd123}});
    wait_fetch_done("idle_after_line8", 600);
    applyStimulus(1'b0, 9'd7, 10'd0, 1'b0, 64'd0);
    tick(2);
    checkOutput("underrun_final", {63'd0, underrun}, 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
